// File: rtl/idexe_stage_elastic.sv
// ID/EX pipeline register with valid/ready handshake, flush and optional skid entry.
// Carries the decode bundle into EXE; counts stall cycles and effective flushes.
module idexe_stage_elastic #(
    parameter int CTRL_W = 13,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int FWD_W  = 2,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [DATA_W-1:0] in_pc_next,
    input  logic [REG_W-1:0]  in_rs,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [FWD_W-1:0]  in_fwd_c,
    input  logic [FWD_W-1:0]  in_fwd_d,
    input  logic              in_pred,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_pc_next,
    output logic [REG_W-1:0]  out_rs,
    output logic [REG_W-1:0]  out_rt,
    output logic [REG_W-1:0]  out_rd,
    output logic [FWD_W-1:0]  out_fwd_c,
    output logic [FWD_W-1:0]  out_fwd_d,
    output logic              out_pred,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int PW = CTRL_W + 4*DATA_W + 3*REG_W + 2*FWD_W + 1;

    logic [PW-1:0]     in_pay;
    logic [PW-1:0]     m_pay;
    logic              m_valid;
    logic              s_valid;
    logic              accept;
    logic [CTRL_W-1:0] m_ctrl;

    assign in_pay = {in_ctrl, in_data1, in_data2, in_imm, in_pc_next,
                     in_rs, in_rt, in_rd, in_fwd_c, in_fwd_d, in_pred};

    assign {m_ctrl, out_data1, out_data2, out_imm, out_pc_next,
            out_rs, out_rt, out_rd, out_fwd_c, out_fwd_d, out_pred} = m_pay;

    // A killed or empty slot must never present a live control word to EXE
    assign out_ctrl  = m_valid ? m_ctrl : '0;
    assign out_valid = m_valid;
    assign accept    = in_valid & in_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic [PW-1:0] s_pay;

            assign in_ready = ~s_valid;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    m_valid <= 1'b0;
                    s_valid <= 1'b0;
                    m_pay   <= '0;
                    s_pay   <= '0;
                end else if (flush) begin
                    m_valid <= 1'b0;
                    s_valid <= 1'b0;
                end else if (!m_valid || out_ready) begin
                    if (s_valid) begin
                        m_pay   <= s_pay;
                        m_valid <= 1'b1;
                        s_valid <= accept;
                        if (accept)
                            s_pay <= in_pay;
                    end else if (accept) begin
                        m_pay   <= in_pay;
                        m_valid <= 1'b1;
                    end else begin
                        m_valid <= 1'b0;
                    end
                end else if (accept) begin
                    s_pay   <= in_pay;
                    s_valid <= 1'b1;
                end
            end
        end else begin : g_noskid
            assign s_valid  = 1'b0;
            assign in_ready = ~m_valid | out_ready;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    m_valid <= 1'b0;
                    m_pay   <= '0;
                end else if (flush) begin
                    m_valid <= 1'b0;
                end else if (accept) begin
                    m_pay   <= in_pay;
                    m_valid <= 1'b1;
                end else if (out_ready) begin
                    m_valid <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (m_valid && !out_ready && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush && (m_valid || s_valid) && !(&flush_cnt))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_idexe_stage_elastic.sv
// Bench for idexe_stage_elastic: skid instance (4-bit counters) and no-skid instance.
// Scoreboard queues hold accepted bundles; the monitor pops them on each consume.
module tb_idexe_stage_elastic;

    localparam int CW = 13;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int FW = 2;
    localparam int PW = CW + 4*DW + 3*RW + 2*FW + 1;

    typedef logic [PW-1:0] w_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic      a_iv, a_fl, a_or;
    w_t        a_in;
    wire       a_ir, a_ov;
    wire [PW-1:0] a_out;
    wire [3:0] a_sc, a_fc;

    logic      b_iv, b_fl, b_or;
    w_t        b_in;
    wire       b_ir, b_ov;
    wire [PW-1:0] b_out;
    wire [15:0] b_sc, b_fc;

    idexe_stage_elastic #(.SKID(1), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_iv), .in_ready(a_ir), .flush(a_fl),
        .in_ctrl(a_in[160:148]), .in_data1(a_in[147:116]),
        .in_data2(a_in[115:84]), .in_imm(a_in[83:52]),
        .in_pc_next(a_in[51:20]), .in_rs(a_in[19:15]),
        .in_rt(a_in[14:10]), .in_rd(a_in[9:5]),
        .in_fwd_c(a_in[4:3]), .in_fwd_d(a_in[2:1]), .in_pred(a_in[0]),
        .out_ctrl(a_out[160:148]), .out_data1(a_out[147:116]),
        .out_data2(a_out[115:84]), .out_imm(a_out[83:52]),
        .out_pc_next(a_out[51:20]), .out_rs(a_out[19:15]),
        .out_rt(a_out[14:10]), .out_rd(a_out[9:5]),
        .out_fwd_c(a_out[4:3]), .out_fwd_d(a_out[2:1]), .out_pred(a_out[0]),
        .out_valid(a_ov), .out_ready(a_or),
        .stall_cnt(a_sc), .flush_cnt(a_fc)
    );

    idexe_stage_elastic #(.SKID(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_iv), .in_ready(b_ir), .flush(b_fl),
        .in_ctrl(b_in[160:148]), .in_data1(b_in[147:116]),
        .in_data2(b_in[115:84]), .in_imm(b_in[83:52]),
        .in_pc_next(b_in[51:20]), .in_rs(b_in[19:15]),
        .in_rt(b_in[14:10]), .in_rd(b_in[9:5]),
        .in_fwd_c(b_in[4:3]), .in_fwd_d(b_in[2:1]), .in_pred(b_in[0]),
        .out_ctrl(b_out[160:148]), .out_data1(b_out[147:116]),
        .out_data2(b_out[115:84]), .out_imm(b_out[83:52]),
        .out_pc_next(b_out[51:20]), .out_rs(b_out[19:15]),
        .out_rt(b_out[14:10]), .out_rd(b_out[9:5]),
        .out_fwd_c(b_out[4:3]), .out_fwd_d(b_out[2:1]), .out_pred(b_out[0]),
        .out_valid(b_ov), .out_ready(b_or),
        .stall_cnt(b_sc), .flush_cnt(b_fc)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input w_t got, input w_t exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic w_t rnd_pay();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        t[148] = 1'b1;
        return t[PW-1:0];
    endfunction

    w_t qa[$];
    w_t qb[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (a_ov && a_or) begin
                if (qa.size() == 0) check("a_unexpected", w_t'(a_ov), '0);
                else check("a_out", a_out, qa.pop_front());
            end
            if (a_fl) qa.delete();
            else if (a_iv && a_ir) qa.push_back(a_in);
            if (b_ov && b_or) begin
                if (qb.size() == 0) check("b_unexpected", w_t'(b_ov), '0);
                else check("b_out", b_out, qb.pop_front());
            end
            if (b_fl) qb.delete();
            else if (b_iv && b_ir) qb.push_back(b_in);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    w_t p, pa, pb, pc, pg;

    initial begin
        a_iv = 0; a_fl = 0; a_or = 0; a_in = '0;
        b_iv = 0; b_fl = 0; b_or = 0; b_in = '0;
        #2;
        check("rst_a_ov", w_t'(a_ov), '0);
        check("rst_a_ir", w_t'(a_ir), w_t'(1));
        check("rst_a_out", a_out, '0);
        check("rst_a_sc", w_t'(a_sc), '0);
        check("rst_a_fc", w_t'(a_fc), '0);
        check("rst_b_ov", w_t'(b_ov), '0);
        check("rst_b_ir", w_t'(b_ir), w_t'(1));
        check("rst_b_out", b_out, '0);
        @(negedge clk);
        rst = 0;
        step();

        // streaming, one bundle per cycle
        a_or = 1;
        for (int k = 0; k < 6; k++) begin
            p = rnd_pay();
            if (k == 0) begin
                p[160:148] = 13'h1A5;
                p[147:116] = 32'hDEADBEEF;
                p[9:5]     = 5'd9;
                pa = p;
            end
            a_iv = 1; a_in = p;
            @(negedge clk);
            check("str_ready", w_t'(a_ir), w_t'(1));
            if (k > 0) check("str_valid", w_t'(a_ov), w_t'(1));
            if (k == 1) begin
                check("str_ctrl", w_t'(a_out[160:148]), w_t'(13'h1A5));
                check("str_data1", w_t'(a_out[147:116]), w_t'(32'hDEADBEEF));
                check("str_rd", w_t'(a_out[9:5]), w_t'(5'd9));
            end
            step();
        end
        a_iv = 0;
        @(negedge clk);
        check("str_last", w_t'(a_ov), w_t'(1));
        step();
        @(negedge clk);
        check("str_empty", w_t'(a_ov), '0);
        check("str_drained", w_t'(qa.size()), '0);

        // backpressure into the skid entry
        step();
        a_or = 0;
        pa = rnd_pay(); pb = rnd_pay(); pc = rnd_pay();
        a_iv = 1; a_in = pa;
        @(negedge clk);
        check("bp_rdy0", w_t'(a_ir), w_t'(1));
        step(); a_in = pb;
        @(negedge clk);
        check("bp_rdy1", w_t'(a_ir), w_t'(1));
        check("bp_hold1", a_out, pa);
        step(); a_in = pc;
        @(negedge clk);
        check("bp_rdy2", w_t'(a_ir), '0);
        check("bp_hold2", a_out, pa);
        step();
        @(negedge clk);
        check("bp_rdy3", w_t'(a_ir), '0);
        check("bp_hold3", a_out, pa);
        step(); a_or = 1;
        @(negedge clk);
        check("bp_stall", w_t'(a_sc), w_t'(3));
        check("bp_rdy4", w_t'(a_ir), '0);
        step();
        @(negedge clk);
        check("bp_rdy5", w_t'(a_ir), w_t'(1));
        step(); a_iv = 0;
        repeat (3) step();
        check("bp_drained", w_t'(qa.size()), '0);

        // flush with M and S full and an input offered
        a_or = 0;
        a_iv = 1; a_in = rnd_pay();
        step(); a_in = rnd_pay();
        step(); a_in = rnd_pay(); a_fl = 1;
        step(); a_fl = 0; a_iv = 0;
        @(negedge clk);
        check("fl_valid", w_t'(a_ov), '0);
        check("fl_ctrl", w_t'(a_out[160:148]), '0);
        check("fl_ready", w_t'(a_ir), w_t'(1));
        check("fl_cnt1", w_t'(a_fc), w_t'(1));
        pg = rnd_pay();
        step(); a_iv = 1; a_in = pg;
        step(); a_in = rnd_pay(); a_fl = 1;
        step(); a_fl = 0; a_iv = 0; a_or = 1;
        @(negedge clk);
        check("fl2_valid", w_t'(a_ov), '0);
        check("fl2_cnt", w_t'(a_fc), w_t'(2));
        check("fl2_payload", w_t'(a_out[147:0]), w_t'(pg[147:0]));
        step(); a_fl = 1;
        step(); a_fl = 0;
        @(negedge clk);
        check("fl_empty_cnt", w_t'(a_fc), w_t'(2));
        check("fl_empty_valid", w_t'(a_ov), '0);

        // stall counter saturation
        step();
        a_or = 0; a_iv = 1; a_in = rnd_pay();
        step(); a_iv = 0;
        repeat (20) step();
        @(negedge clk);
        check("sat_stall", w_t'(a_sc), w_t'(4'hF));
        step(); a_or = 1;
        repeat (2) step();
        check("sat_drained", w_t'(qa.size()), '0);

        // no-skid: combinational ready, back-to-back without bubble
        b_or = 0; b_iv = 1; b_in = rnd_pay();
        @(negedge clk);
        check("b_rdy_empty", w_t'(b_ir), w_t'(1));
        step(); b_in = rnd_pay();
        #1;
        check("b_comb_lo", w_t'(b_ir), '0);
        b_or = 1;
        #1;
        check("b_comb_hi", w_t'(b_ir), w_t'(1));
        step(); b_in = rnd_pay();
        @(negedge clk);
        check("b_b2b_1", w_t'(b_ov), w_t'(1));
        step(); b_iv = 0;
        @(negedge clk);
        check("b_b2b_2", w_t'(b_ov), w_t'(1));
        step();
        @(negedge clk);
        check("b_empty", w_t'(b_ov), '0);
        check("b_stall", w_t'(b_sc), '0);
        check("b_drained", w_t'(qb.size()), '0);

        // asynchronous reset between clock edges
        step();
        a_or = 0; b_or = 0;
        a_iv = 1; b_iv = 1; a_in = rnd_pay(); b_in = rnd_pay();
        repeat (3) step();
        #2;
        rst = 1;
        #1;
        check("arst_a_ov", w_t'(a_ov), '0);
        check("arst_a_out", a_out, '0);
        check("arst_a_ir", w_t'(a_ir), w_t'(1));
        check("arst_a_sc", w_t'(a_sc), '0);
        check("arst_a_fc", w_t'(a_fc), '0);
        check("arst_b_ov", w_t'(b_ov), '0);
        check("arst_b_out", b_out, '0);
        check("arst_b_ir", w_t'(b_ir), w_t'(1));
        check("arst_b_sc", w_t'(b_sc), '0);
        a_iv = 0; b_iv = 0;
        qa.delete(); qb.delete();
        step();
        rst = 0;
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/idexe_stage_elastic.md
Name: idexe_stage_elastic

Overview:
- Parametrised ID/EX pipeline stage register with a valid/ready handshake, flush and an optional skid buffer.
- Carries the decode bundle into the EXE stage: control word, two operands, sign-extended immediate, rs/rt/rd, next PC, forward selects C/D and the branch prediction bit.
- Supports hazard-unit stalls (backpressure), branch-mispredict flushes and stall/flush statistics.
- Sits between the register-file/decode logic and the ALU/forwarding muxes.

Parameters:
- CTRL_W, 13, control-unit signal bundle width
- DATA_W, 32, operand / immediate / PC width
- REG_W, 5, register address width
- FWD_W, 2, forward-select width (C and D)
- SKID, 1, 1 = two-entry skid buffer with in_ready registered; 0 = single register with in_ready combinational
- CNT_W, 16, statistics counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  decode bundle valid
- in_ready  out  1  stage can accept
- flush  in  1  synchronous kill of all held entries
- in_ctrl / out_ctrl  in/out  CTRL_W  control word
- in_data1, in_data2 / out_data1, out_data2  in/out  DATA_W  register operands
- in_imm / out_imm  in/out  DATA_W  sign-extended immediate
- in_pc_next / out_pc_next  in/out  DATA_W  PC+4
- in_rs, in_rt, in_rd / out_rs, out_rt, out_rd  in/out  REG_W  register addresses
- in_fwd_c, in_fwd_d / out_fwd_c, out_fwd_d  in/out  FWD_W  forward selects
- in_pred / out_pred  in/out  1  branch prediction taken
- out_valid  out  1  EXE bundle valid
- out_ready  in  1  EXE consumes bundle
- stall_cnt  out  CNT_W  saturating stall-cycle count
- flush_cnt  out  CNT_W  saturating count of flushes that killed an entry

Behaviour:
- Reset is asynchronous and active-high on rst, clocked by clk.
- Reset values:
  - M_valid = 0, S_valid = 0.
  - All payload registers = 0; all out_* = 0.
  - out_valid = 0, in_ready = 1.
  - stall_cnt = 0, flush_cnt = 0.
- Handshakes:
  - Accept on the rising edge when in_valid & in_ready.
  - Consume when out_valid & out_ready.
  - in_valid may rise independent of in_ready; the payload must be held by the source until accepted.
- Storage: main register M drives out_*; skid register S exists only when SKID=1.
- out_valid = M_valid.
- Bubble guarantee: out_ctrl = M_valid ? M.ctrl : 0. Other out_* always show M contents.
- Latency: 1 cycle from accept to out_valid (empty stage).
- SKID=0:
  - in_ready = ~M_valid | out_ready.
  - On accept, M loads input.
  - On consume without accept, M_valid clears.
- SKID=1:
  - in_ready = ~S_valid, taken straight from a flop; no combinational path from out_ready.
  - If M is empty or consumed: M loads S if S_valid (and S_valid clears), else loads the accepted input if any, else M_valid clears.
  - If an input is accepted while M is full and not consumed: the input goes to S.
  - If S_valid and M is consumed in the same cycle as an accept: M<-S, S<-input.
  - Full condition (M_valid & S_valid) gives in_ready=0 next cycle. Ordering is strictly FIFO.
- Flush:
  - Synchronous; priority above everything except rst.
  - Next cycle M_valid=0 and S_valid=0; an input accepted in the flush cycle is discarded.
  - Payload registers hold their values; out_ctrl reads 0.
  - in_ready is 1 the cycle after a flush.
- Counters:
  - stall_cnt increments on each cycle with out_valid & ~out_ready.
  - flush_cnt increments on each flush cycle where M_valid | S_valid.
  - Both saturate at all-ones and are not cleared by flush.
- Simultaneous accept and consume when SKID=0: M reloads and out_valid stays 1 (no bubble).
- rst mid-transfer drops all entries immediately; no partial outputs.

Test Plan:
- Reset then stream, SKID=1: in_valid=1 with in_ctrl=13'h1A5, in_data1=32'hDEADBEEF, rd=5'd9, out_ready=1 -> out_valid=1 one cycle later, fields exact, 1 bundle/cycle sustained.
- Backpressure, SKID=1: out_ready=0 for 3 cycles while sending bundles A,B,C.
  - Required: A holds on out_*; B goes to S; in_ready=0 from the cycle after B is accepted.
  - C is held by the source and not accepted.
  - Release gives A,B,C in order; stall_cnt=3.
- Flush with M and S full plus in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1, flush_cnt=1, and the input offered in the flush cycle never appears at the output.
- SKID=0, out_ready=0 with M full -> in_ready=0 in the same cycle; raising out_ready gives in_ready=1 in that same cycle (combinational), with back-to-back transfer and no bubble.
- Counter saturation, CNT_W=4: hold a stall for 20 cycles -> stall_cnt stays at 4'hF.
- Async reset asserted mid-stream, between clock edges -> outputs and counters go to 0 immediately and in_ready=1.
